// File: rtl/avalon_mm_pkg.sv
// Avalon-MM master shared types.
// FSM states, error codes, default widths.
package avalon_mm_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_TIMEOUT,
    ERR_BYTEEN
  } err_e;

endpackage

// File: rtl/avalon_mm_master_timeout.sv
// Saturating stall counter for the Avalon-MM master.
// Pulses expired while enabled at LIMIT-1.
module bus_timeout_counter
  import avalon_mm_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // count stalled cycles, hold at LAST
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && cnt_q < LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // counter register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !clear && (cnt_q >= LAST);

endmodule

// File: rtl/avalon_mm_master.sv
// Single-outstanding Avalon-MM master.
// Load/store port in, one bus transfer out.
module avalon_mm_master
  import avalon_mm_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_byteen,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  localparam int BW = DATA_W / 8;

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BW-1:0]     be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              expired;

  bus_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (state_q != BUS),
    .enable  (state_q == BUS && avm_waitrequest),
    .expired (expired)
  );

  // next state, request latch, response capture
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_byteen;
          if (req_byteen == '0) begin
            state_d = RESP;
            err_d   = ERR_BYTEEN;
            rdata_d = '0;
          end else begin
            state_d = BUS;
            err_d   = ERR_NONE;
          end
        end
      end
      BUS: begin
        if (!avm_waitrequest) begin
          state_d = RESP;
          err_d   = ERR_NONE;
          rdata_d = write_q ? '0 : avm_readdata;
        end else if (expired) begin
          state_d = RESP;
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign avm_read       = (state_q == BUS) && !write_q;
  assign avm_write      = (state_q == BUS) && write_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;
  assign resp_valid     = (state_q == RESP);
  assign resp_err       = (state_q == RESP) && (err_q != ERR_NONE);
  assign resp_rdata     = rdata_q;

endmodule

// File: tb/tb_avalon_mm_master.sv
// Scoreboard bench for avalon_mm_master.
// Directed loads/stores against a small slave model.
module tb_avalon_mm_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_byteen = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [DW-1:0] avm_writedata;
  logic [BW-1:0] avm_byteenable;
  logic [DW-1:0] avm_readdata;
  logic          avm_waitrequest;

  avalon_mm_master #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_byteen      (req_byteen),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // slave: timer register at 0x4 reads 0x10, others read 0x1000_0000|addr
  int   scnt = 0;
  int   wait_n = 0;
  logic stuck = 1'b0;

  always @(posedge clock) begin
    if (avm_read || avm_write) scnt <= scnt + 1;
    else scnt <= 0;
  end

  assign avm_waitrequest = stuck || (scnt < wait_n);
  assign avm_readdata = (avm_address == 32'h4) ? 32'h10
                      : (32'h1000_0000 | avm_address);

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];

  logic          cur_write = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  logic [BW-1:0] cur_be = '0;
  int            strobes_seen = 0;

  // monitor: bus stability and response scoreboard
  always @(negedge clock) begin
    exp_t e;
    if (avm_read || avm_write) begin
      strobes_seen++;
      check("one_strobe", 64'(avm_read && avm_write), 64'(0));
      check("strobe_dir", 64'(avm_write), 64'(cur_write));
      check("bus_addr", 64'(avm_address), 64'(cur_addr));
      check("bus_be", 64'(avm_byteenable), 64'(cur_be));
      if (avm_write)
        check("bus_wdata", 64'(avm_writedata), 64'(cur_wdata));
    end
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("resp_err", 64'(resp_err), 64'(e.err));
        check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
        check("resp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic do_req(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input int wn, input logic st,
                        input logic eerr, input logic [31:0] erd,
                        input int estr);
    bit got;
    got = 0;
    @(negedge clock);
    wait_n = wn;
    stuck = st;
    cur_write = w;
    cur_addr = a;
    cur_wdata = d;
    cur_be = be;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    req_byteen = be;
    req_valid = 1'b1;
    strobes_seen = 0;
    check("ready_idle", 64'(req_ready), 64'(1));
    sb.push_back('{eerr, erd, 32'(cyc + 1 + estr)});
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (resp_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) check("resp_wait", 64'(0), 64'(1));
    @(negedge clock);
    check("ready_after", 64'(req_ready), 64'(1));
    check("strobe_cycles", 64'(strobes_seen), 64'(estr));
    stuck = 1'b0;
    wait_n = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] b2b_a [3];
  logic [31:0] b2b_e [3];
  int          acc [3];

  initial begin
    b2b_a[0] = 32'h20; b2b_e[0] = 32'h1000_0020;
    b2b_a[1] = 32'h24; b2b_e[1] = 32'h1000_0024;
    b2b_a[2] = 32'h28; b2b_e[2] = 32'h1000_0028;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_read", 64'(avm_read), 64'(0));
    check("rst_write", 64'(avm_write), 64'(0));
    check("rst_rvalid", 64'(resp_valid), 64'(0));
    check("rst_rerr", 64'(resp_err), 64'(0));
    check("rst_rdata", 64'(resp_rdata), 64'(0));
    check("rst_addr", 64'(avm_address), 64'(0));
    resetn = 1'b1;

    do_req(1'b0, 32'h4, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h10, 1);
    do_req(1'b1, 32'h8, 32'h3, 4'hF, 3, 1'b0, 1'b0, 32'h0, 4);
    do_req(1'b0, 32'hC, 32'h0, 4'hF, 0, 1'b1, 1'b1, 32'h0, TO);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 1'b1, 32'h0, 0);
    do_req(1'b1, 32'h14, 32'hDEAD, 4'h3, 1, 1'b0, 1'b0, 32'h0, 2);

    @(negedge clock);
    stuck = 1'b1;
    cur_write = 1'b0;
    cur_addr = 32'h30;
    cur_be = 4'hF;
    req_write = 1'b0;
    req_addr = 32'h30;
    req_byteen = 4'hF;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check("mid_rst_read", 64'(avm_read), 64'(0));
    check("mid_rst_write", 64'(avm_write), 64'(0));
    check("mid_rst_ready", 64'(req_ready), 64'(1));
    check("mid_rst_rvalid", 64'(resp_valid), 64'(0));
    resetn = 1'b1;
    stuck = 1'b0;
    repeat (5) @(negedge clock);
    do_req(1'b0, 32'h4, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h10, 1);

    wait_n = 0;
    cur_write = 1'b0;
    cur_be = 4'hF;
    req_write = 1'b0;
    req_byteen = 4'hF;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = 0;
      @(negedge clock);
      while (!req_ready && k < 20) begin
        @(negedge clock);
        k++;
      end
      check("b2b_ready", 64'(req_ready), 64'(1));
      req_addr = b2b_a[i];
      cur_addr = b2b_a[i];
      req_valid = 1'b1;
      acc[i] = cyc;
      sb.push_back('{1'b0, b2b_e[i], 32'(cyc + 2)});
      @(posedge clock);
    end
    #1 req_valid = 1'b0;
    repeat (6) @(negedge clock);
    check("b2b_gap01", 64'(acc[1] - acc[0]), 64'(3));
    check("b2b_gap12", 64'(acc[2] - acc[1]), 64'(3));
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
